// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope.
// Scales a signed 24-bit oscillator sample by a 16-bit envelope level. The level
// advances on a prescaled tick (one tick every DIV clk48m cycles). Gate edges are
// seen on every clock and override a coincident tick.
// Build option: define EXP_RELEASE_EN for an exponential release tail
// (step = (level >> release_rate[3:0]) + 1); otherwise the release is linear.
module adsr_envelope #(
    parameter int unsigned DIV = 1000
) (
    input  logic        clk48m,
    input  logic        rst,
    input  logic        gate,
    input  logic [15:0] attack_rate,
    input  logic [15:0] decay_rate,
    input  logic [15:0] sustain_level,
    input  logic [15:0] release_rate,
    input  logic [23:0] sample_in,
    output logic [23:0] sample_out,
    output logic [15:0] env_level,
    output logic        active
);

    localparam int unsigned CW = $clog2(DIV);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t               state;
    logic [CW-1:0]        prescale;
    logic                 tick;
    logic                 gate_d;
    logic                 rise;
    logic                 fall;
    logic [16:0]          attack_sum;
    logic                 attack_full;
    logic                 decay_hold;
    logic [15:0]          decay_diff;
    logic                 decay_done;
    logic [16:0]          release_step;
    logic                 release_done;
    logic signed [40:0]   product;

    assign tick = (prescale == CW'(DIV - 1));
    assign rise = gate & ~gate_d;
    assign fall = ~gate & gate_d;

    // Free-running envelope prescaler, wraps at DIV-1.
    always_ff @(posedge clk48m or posedge rst) begin
        if (rst) begin
            prescale <= '0;
        end else if (tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + CW'(1);
        end
    end

    // Gate history for edge detection.
    always_ff @(posedge clk48m or posedge rst) begin
        if (rst) begin
            gate_d <= 1'b0;
        end else begin
            gate_d <= gate;
        end
    end

    // Per-phase next-level arithmetic and end-of-phase conditions.
    always_comb begin
        attack_sum  = {1'b0, env_level} + {1'b0, attack_rate};
        attack_full = (attack_rate == 16'h0000) || attack_sum[16] ||
                      (attack_sum[15:0] == 16'hffff);
        decay_hold  = (env_level <= sustain_level);
        decay_diff  = env_level - sustain_level;
        decay_done  = (decay_rate == 16'h0000) || (decay_diff <= decay_rate);
`ifdef EXP_RELEASE_EN
        release_step = {1'b0, env_level >> release_rate[3:0]} + 17'd1;
        release_done = ({1'b0, env_level} <= release_step);
`else
        release_step = {1'b0, release_rate};
        release_done = (release_rate == 16'h0000) ||
                       ({1'b0, env_level} <= release_step);
`endif
    end

    // Envelope state machine: gate edges first, then tick-driven level steps.
    always_ff @(posedge clk48m or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            env_level <= 16'h0000;
            active    <= 1'b0;
        end else if (rise) begin
            // Retrigger keeps the current level.
            state  <= ATTACK;
            active <= 1'b1;
        end else if (fall) begin
            if ((state == ATTACK) || (state == DECAY) || (state == SUSTAIN)) begin
                state <= RELEASE;
            end else begin
                state <= state;
            end
        end else if (tick) begin
            case (state)
                IDLE: begin
                    env_level <= 16'h0000;
                    active    <= 1'b0;
                end
                ATTACK: begin
                    if (attack_full) begin
                        env_level <= 16'hffff;
                        state     <= DECAY;
                    end else begin
                        env_level <= attack_sum[15:0];
                    end
                end
                DECAY: begin
                    if (decay_hold) begin
                        state <= SUSTAIN;
                    end else if (decay_done) begin
                        env_level <= sustain_level;
                        state     <= SUSTAIN;
                    end else begin
                        env_level <= env_level - decay_rate;
                    end
                end
                SUSTAIN: begin
                    env_level <= sustain_level;
                end
                RELEASE: begin
                    if (release_done) begin
                        env_level <= 16'h0000;
                        state     <= IDLE;
                        active    <= 1'b0;
                    end else begin
                        env_level <= env_level - release_step[15:0];
                    end
                end
                default: begin
                    env_level <= 16'h0000;
                    state     <= IDLE;
                    active    <= 1'b0;
                end
            endcase
        end else begin
            state <= state;
        end
    end

    // Signed sample times unsigned level; keep bits 39:16 (floor division by 2^16).
    always_comb begin
        product = $signed(sample_in) * $signed({1'b0, env_level});
    end

    // Registered scaled output.
    always_ff @(posedge clk48m or posedge rst) begin
        if (rst) begin
            sample_out <= 24'h000000;
        end else begin
            sample_out <= product[39:16];
        end
    end

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed testbench for adsr_envelope with DIV=4.
module tb_adsr_envelope;

    logic        clk48m;
    logic        rst;
    logic        gate;
    logic [15:0] attack_rate;
    logic [15:0] decay_rate;
    logic [15:0] sustain_level;
    logic [15:0] release_rate;
    logic [23:0] sample_in;
    logic [23:0] sample_out;
    logic [15:0] env_level;
    logic        active;

    int checks;
    int errors;

    adsr_envelope #(.DIV(4)) dut (
        .clk48m        (clk48m),
        .rst           (rst),
        .gate          (gate),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .sample_in     (sample_in),
        .sample_out    (sample_out),
        .env_level     (env_level),
        .active        (active)
    );

    initial clk48m = 1'b0;
    always #5 clk48m = ~clk48m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) on negedges until env_level differs from its value at entry.
    task automatic wait_change(input int budget, output int cycles);
        logic [15:0] prev;
        prev   = env_level;
        cycles = 0;
        do begin
            @(negedge clk48m);
            cycles++;
        end while ((env_level == prev) && (cycles < budget));
    endtask

    logic [15:0] dec_exp [8] = '{16'hefff, 16'hdfff, 16'hcfff, 16'hbfff,
                                 16'hafff, 16'h9fff, 16'h8fff, 16'h8000};
    logic [15:0] att_exp [4] = '{16'h4000, 16'h8000, 16'hc000, 16'hffff};

    initial begin
        int cyc;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        gate          = 1'b0;
        attack_rate   = 16'h4000;
        decay_rate    = 16'h1000;
        sustain_level = 16'h8000;
`ifdef EXP_RELEASE_EN
        release_rate  = 16'h0004;
`else
        release_rate  = 16'h0300;
`endif
        sample_in     = 24'h7fffff;

        // 1: reset and idle
        repeat (3) @(negedge clk48m);
        check("rst_level", env_level, 16'h0000);
        check("rst_active", active, 1'b0);
        check("rst_out", sample_out, 24'h000000);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk48m);
            check("idle_level", env_level, 16'h0000);
            check("idle_active", active, 1'b0);
            check("idle_out", sample_out, 24'h000000);
        end

        // 2: attack
        gate = 1'b1;
        @(negedge clk48m);
        check("attack_active", active, 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_change(8, cyc);
            check("attack_level", env_level, att_exp[i]);
            if (i > 0) check("attack_interval", cyc, 4);
        end

        // 3: decay to sustain and hold
        for (int i = 0; i < 8; i++) begin
            wait_change(8, cyc);
            check("decay_level", env_level, dec_exp[i]);
            check("decay_interval", cyc, 4);
        end
        repeat (12) @(negedge clk48m);
        check("sustain_hold", env_level, 16'h8000);
        check("sustain_active", active, 1'b1);

        // 4: scaling at level 0x8000
        sample_in = 24'h7fffff;
        @(negedge clk48m);
        check("scale_pos_rail", sample_out, 24'h3fffff);
        sample_in = 24'h800000;
        @(negedge clk48m);
        check("scale_neg_rail", sample_out, 24'hc00000);
        sample_in = 24'hffffff;
        @(negedge clk48m);
        check("scale_floor", sample_out, 24'hffffff);
        sample_in = 24'h000100;
        @(negedge clk48m);
        check("scale_small", sample_out, 24'h000080);

        // 3b: sustain level tracked
        sustain_level = 16'h6000;
        wait_change(8, cyc);
        check("sustain_track", env_level, 16'h6000);
        sample_in = 24'h7fffff;
        @(negedge clk48m);
        check("scale_6000", sample_out, 24'h2fffff);

        // 5: release from 0x0800
        sustain_level = 16'h0800;
        wait_change(8, cyc);
        check("sustain_0800", env_level, 16'h0800);
        gate = 1'b0;
`ifdef EXP_RELEASE_EN
        wait_change(8, cyc);
        check("exp_release_1", env_level, 16'h077f);
        cyc = 0;
        while (active && (cyc < 4000)) begin
            @(negedge clk48m);
            cyc++;
        end
`else
        wait_change(8, cyc);
        check("release_1", env_level, 16'h0500);
        wait_change(8, cyc);
        check("release_2", env_level, 16'h0200);
        check("release_interval", cyc, 4);
        wait_change(8, cyc);
        check("release_3", env_level, 16'h0000);
`endif
        check("release_idle_active", active, 1'b0);
        check("release_idle_level", env_level, 16'h0000);

        // 6: gate rise coinciding with a tick while in RELEASE
        attack_rate = 16'h3000;
        gate = 1'b1;
        wait_change(8, cyc);
        check("retrig_attack", env_level, 16'h3000);
        gate = 1'b0;
        @(negedge clk48m);
        @(negedge clk48m);
        check("rel_hold_a", env_level, 16'h3000);
        @(negedge clk48m);
        check("rel_hold_b", env_level, 16'h3000);
        gate = 1'b1;
        @(negedge clk48m);
        check("edge_vs_tick_level", env_level, 16'h3000);
        check("edge_vs_tick_active", active, 1'b1);
        wait_change(8, cyc);
        check("retrig_next", env_level, 16'h6000);
        check("retrig_interval", cyc, 4);

        // 7: reset mid-note, gate held high through release of reset
        rst = 1'b1;
        #1;
        check("midrst_level", env_level, 16'h0000);
        check("midrst_active", active, 1'b0);
        check("midrst_out", sample_out, 24'h000000);
        @(negedge clk48m);
        rst = 1'b0;
        @(negedge clk48m);
        check("post_rst_active", active, 1'b1);
        check("post_rst_level", env_level, 16'h0000);
        wait_change(8, cyc);
        check("post_rst_attack", env_level, 16'h3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
